// File: rtl/decade_down_counter.sv
// decade_down_counter: cascadable BCD down-counter with load, wrap/hold at zero,
// and registered done / borrow / load_err pulses.
module decade_down_counter #(
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic                  wrap,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  done,
  output logic                  borrow,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  logic [W-1:0] dec_val;
  logic [W-1:0] count_n;
  logic         load_ok;
  logic         count_is_zero;
  logic         dec_is_zero;
  logic         done_n;
  logic         borrow_n;
  logic         err_n;
  logic         low_zero;
  logic [3:0]   dig;

  // BCD predecessor via a borrow chain; a digit at 0 that borrows becomes 9
  always_comb begin
    dec_val  = count;
    low_zero = 1'b1;
    dig      = 4'd0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = count[4*i +: 4];
      if (low_zero) begin
        dec_val[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
      end
      low_zero = low_zero & (dig == 4'd0);
    end
  end

  // Load legality: every digit must be a valid BCD digit
  always_comb begin
    load_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) begin
        load_ok = 1'b0;
      end
    end
  end

  // Next count and pulse values; load has priority over en
  always_comb begin
    count_n       = count;
    done_n        = 1'b0;
    borrow_n      = 1'b0;
    err_n         = 1'b0;
    count_is_zero = (count == W'(0));
    dec_is_zero   = (dec_val == W'(0));
    if (load) begin
      if (load_ok) begin
        count_n = load_val;
      end else begin
        err_n = 1'b1;
      end
    end else if (en) begin
      if (count_is_zero) begin
        if (wrap) begin
          count_n  = dec_val;
          borrow_n = 1'b1;
        end
      end else begin
        count_n = dec_val;
        done_n  = dec_is_zero;
      end
    end
  end

  // State register; zero is registered alongside count so it always tracks it
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= W'(0);
      zero     <= 1'b1;
      done     <= 1'b0;
      borrow   <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_n;
      zero     <= (count_n == W'(0));
      done     <= done_n;
      borrow   <= borrow_n;
      load_err <= err_n;
    end
  end

endmodule

// File: tb/tb_decade_down_counter.sv
// Directed self-checking bench for decade_down_counter (DIGITS = 2).
module tb_decade_down_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic       wrap = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] count;
  logic       zero;
  logic       done;
  logic       borrow;
  logic       load_err;

  int n_vec = 0;
  int n_err = 0;

  decade_down_counter #(.DIGITS(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .wrap     (wrap),
    .load_val (load_val),
    .count    (count),
    .zero     (zero),
    .done     (done),
    .borrow   (borrow),
    .load_err (load_err)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs at the falling edge, then sample 1 time unit after the rising edge
  task automatic step(input logic r, input logic e, input logic l, input logic w,
                      input logic [7:0] v);
    @(negedge clk);
    rst = r; en = e; load = l; wrap = w; load_val = v;
    @(posedge clk);
    #1;
  endtask

  // Reference BCD predecessor via integer arithmetic
  function automatic logic [7:0] pred(input logic [7:0] v, input logic w);
    int n;
    logic [7:0] r;
    n = int'(v[7:4]) * 10 + int'(v[3:0]);
    if (n == 0) n = w ? 99 : 0;
    else n = n - 1;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  task automatic check_all(input string tag, input logic [7:0] c, input logic d,
                           input logic b, input logic le);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".zero"}, 32'(zero), 32'(c == 8'h00));
    check({tag, ".done"}, 32'(done), 32'(d));
    check({tag, ".borrow"}, 32'(borrow), 32'(b));
    check({tag, ".load_err"}, 32'(load_err), 32'(le));
  endtask

  initial begin
    logic [7:0] exp_c;
    logic [7:0] prev;
    int nb;
    int nd;
    logic digit_ok;

    // Reset with en and load asserted
    step(1, 1, 1, 0, 8'h55);
    check_all("rst1", 8'h00, 0, 0, 0);
    step(1, 1, 1, 0, 8'h55);
    check_all("rst2", 8'h00, 0, 0, 0);
    step(0, 0, 0, 0, 8'h00);
    check_all("hold1", 8'h00, 0, 0, 0);
    step(0, 0, 0, 0, 8'h00);
    check_all("hold2", 8'h00, 0, 0, 0);

    // Load 12 and count down to 00 with wrap = 0
    step(0, 0, 1, 0, 8'h12);
    check_all("load12", 8'h12, 0, 0, 0);
    exp_c = 8'h12;
    for (int i = 0; i < 12; i++) begin
      prev = exp_c;
      exp_c = pred(exp_c, 1'b0);
      step(0, 1, 0, 0, 8'h00);
      check_all("down", exp_c, (prev != 8'h00) && (exp_c == 8'h00), 0, 0);
    end
    check("down.end", 32'(count), 32'h00);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 8'h00);
      check_all("holdzero", 8'h00, 0, 0, 0);
    end

    // Wrap through zero
    step(0, 0, 1, 1, 8'h01);
    check_all("load01", 8'h01, 0, 0, 0);
    step(0, 1, 0, 1, 8'h00);
    check_all("wrap00", 8'h00, 1, 0, 0);
    step(0, 1, 0, 1, 8'h00);
    check_all("wrap99", 8'h99, 0, 1, 0);
    step(0, 1, 0, 1, 8'h00);
    check_all("wrap98", 8'h98, 0, 0, 0);

    // Illegal load rejected, later legal load accepted
    step(0, 0, 1, 0, 8'h45);
    check_all("load45", 8'h45, 0, 0, 0);
    step(0, 0, 1, 0, 8'h3A);
    check_all("load3A", 8'h45, 0, 0, 1);
    step(0, 0, 0, 0, 8'h00);
    check_all("errclr", 8'h45, 0, 0, 0);
    step(0, 0, 1, 0, 8'h90);
    check_all("load90", 8'h90, 0, 0, 0);

    // Load beats en; reset beats en
    step(0, 0, 1, 0, 8'h20);
    check_all("load20", 8'h20, 0, 0, 0);
    step(0, 1, 1, 0, 8'h07);
    check_all("loaden", 8'h07, 0, 0, 0);
    step(1, 1, 0, 0, 8'h00);
    check_all("rsten", 8'h00, 0, 0, 0);

    // Long wrapping run from 00
    step(0, 0, 1, 1, 8'h00);
    check_all("load00", 8'h00, 0, 0, 0);
    exp_c = 8'h00;
    nb = 0;
    nd = 0;
    digit_ok = 1'b1;
    for (int i = 0; i < 250; i++) begin
      exp_c = pred(exp_c, 1'b1);
      step(0, 1, 0, 1, 8'h00);
      if (count[7:4] > 4'd9 || count[3:0] > 4'd9) digit_ok = 1'b0;
      if (borrow === 1'b1) nb++;
      if (done === 1'b1) nd++;
      if (count !== exp_c) check("long.count", 32'(count), 32'(exp_c));
    end
    check("long.digits", 32'(digit_ok), 32'd1);
    check("long.final", 32'(count), 32'h50);
    check("long.borrows", 32'(nb), 32'd3);
    check("long.dones", 32'(nd), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
